// File: rtl/sprite_writer.sv
// Copies one SPRITE_DIM x SPRITE_DIM sprite from the sprite ROM into the 256x256 frame RAM.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (skip pixels equal to TRANSPARENT_IDX).
module sprite_writer #(
   parameter int SPRITE_DIM      = 16,
   parameter int PIXEL_W         = 8,
   parameter int SPRITE_ID_W     = 4,
   parameter int TRANSPARENT_IDX = 0,
   localparam int LW             = $clog2(SPRITE_DIM)
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       START,
   input  logic [7:0]                 SPRITE_X,
   input  logic [7:0]                 SPRITE_Y,
   input  logic [SPRITE_ID_W-1:0]     SPRITE_ID,
   output logic                       BUSY,
   output logic                       DONE,
   output logic [SPRITE_ID_W+2*LW-1:0] ROM_ADDR,
   input  logic [PIXEL_W-1:0]         ROM_DATA,
   input  logic                       WR_ALLOW,
   output logic [15:0]                WRITEADDR,
   output logic [PIXEL_W-1:0]         DATA,
   output logic                       FD_WE_N
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             x_q, x_d, y_q, y_d;
   logic [SPRITE_ID_W-1:0] id_q, id_d;
   logic [LW-1:0]          row_q, row_d, col_q, col_d;
   logic [8:0]             col_sum, row_sum;
   logic                   visible, opaque, we;

   // 9-bit sums so a sprite hanging off the right/bottom edge is clipped, not wrapped.
   assign col_sum = {1'b0, x_q} + 9'(col_q);
   assign row_sum = {1'b0, y_q} + 9'(row_q);
   assign visible = !col_sum[8] && !row_sum[8];

`ifdef SPRITE_TRANSPARENCY_EN
   assign opaque = (ROM_DATA != PIXEL_W'(TRANSPARENT_IDX));
`else
   // Transparency disabled: every pixel is written regardless of its value.
   assign opaque = 1'b1 | (ROM_DATA == PIXEL_W'(TRANSPARENT_IDX));
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      id_d    = id_q;
      row_d   = row_q;
      col_d   = col_q;
      we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               x_d     = SPRITE_X;
               y_d     = SPRITE_Y;
               id_d    = SPRITE_ID;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_WRITE;
         S_WRITE: begin
            we = visible && opaque && WR_ALLOW;
            // Skipped pixels advance at once; drawable ones wait for the write window.
            if (!(visible && opaque) || WR_ALLOW) begin
               col_d = col_q + LW'(1);
               if (&col_q) row_d = row_q + LW'(1);
               state_d = (&col_q && &row_q) ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         id_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         id_q    <= id_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign ROM_ADDR  = {id_q, row_q, col_q};
   assign WRITEADDR = {row_sum[7:0], col_sum[7:0]};
   assign DATA      = ROM_DATA;
   assign FD_WE_N   = !we;
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_writer.sv
// Scoreboard bench for sprite_writer: expected frame RAM writes are queued per copy and
// popped as the DUT writes them; a behavioural sprite ROM answers ROM_ADDR one cycle later.
module tb_sprite_writer;
   localparam int DIM = 16;

   logic        CLK = 1'b0;
   logic        RESET_N, START, WR_ALLOW, BUSY, DONE, FD_WE_N;
   logic [7:0]  SPRITE_X, SPRITE_Y, ROM_DATA, DATA;
   logic [3:0]  SPRITE_ID;
   logic [11:0] ROM_ADDR;
   logic [15:0] WRITEADDR;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [7:0]  data;
      logic [11:0] raddr;
   } wr_t;

   wr_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   int  rom_mode = 0;

   sprite_writer dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .SPRITE_X(SPRITE_X),
      .SPRITE_Y(SPRITE_Y), .SPRITE_ID(SPRITE_ID), .BUSY(BUSY), .DONE(DONE),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .WR_ALLOW(WR_ALLOW),
      .WRITEADDR(WRITEADDR), .DATA(DATA), .FD_WE_N(FD_WE_N)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] pix(int mode, int row, int col);
      if (mode == 0) return 8'(row * 16 + col + 1);
      if (col % 2 == 0) return 8'h00;
      return 8'h80 | 8'(row * 16 + col);
   endfunction

   always @(posedge CLK) ROM_DATA <= pix(rom_mode, int'(ROM_ADDR[7:4]), int'(ROM_ADDR[3:0]));

   task automatic build_exp(input int x, input int y, input int id, input int mode, input int stall);
      wr_t e;
      exp_q.delete();
      for (int p = 0; p < DIM * DIM; p++) begin
         int row = p / DIM, col = p % DIM;
         int cs = x + col, rs = y + row;
         logic [7:0] d = pix(mode, row, col);
         bit draw = (cs < 256) && (rs < 256);
`ifdef SPRITE_TRANSPARENCY_EN
         if (d == 8'h00) draw = 0;
`endif
         if (draw) begin
            e.cyc   = 2 + 2 * p + ((p >= 5) ? stall : 0);
            e.addr  = {8'(rs), 8'(cs)};
            e.data  = d;
            e.raddr = {4'(id), 4'(row), 4'(col)};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic check_write(input string name, input int cyc, inout int nwr);
      wr_t e;
      if (FD_WE_N !== 1'b1) begin
         nwr++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s unexpected write cyc=%0d addr=%h required none", name, cyc, WRITEADDR);
         end else begin
            e = exp_q.pop_front();
            if (cyc !== e.cyc || WRITEADDR !== e.addr || DATA !== e.data || ROM_ADDR !== e.raddr) begin
               fails++;
               $display("FAIL %s write cyc/addr/data/rom got %0d/%h/%h/%h required %0d/%h/%h/%h",
                        name, cyc, WRITEADDR, DATA, ROM_ADDR, e.cyc, e.addr, e.data, e.raddr);
            end
         end
      end
   endtask

   // Runs one copy starting at edge 0; cycle n is sampled on the falling edge after edge n-1.
   task automatic run_copy(input string name, input int x, input int y, input int id,
                           input int mode, input int stall, input bit ign, input int exp_writes);
      int done_cyc = 2 * DIM * DIM + 1 + stall;
      int nwr = 0;
      int cyc = 0;
      build_exp(x, y, id, mode, stall);
      rom_mode = mode;
      @(posedge CLK); #1;
      SPRITE_X = 8'(x); SPRITE_Y = 8'(y); SPRITE_ID = 4'(id);
      START = 1'b1; WR_ALLOW = 1'b1;
      @(posedge CLK);
      repeat (done_cyc + 3) begin
         #1;
         cyc++;
         START = ign && (cyc == 50 || cyc == 513);
         if (START) begin SPRITE_X = 8'(x + 33); SPRITE_Y = 8'(y + 7); SPRITE_ID = 4'(id + 5); end
         WR_ALLOW = !(stall > 0 && cyc >= 12 && cyc < 12 + stall);
         @(negedge CLK);
         tests++;
         if (BUSY !== (cyc <= done_cyc) || DONE !== (cyc == done_cyc)) begin
            fails++;
            $display("FAIL %s busy/done cyc=%0d got %b/%b required %b/%b", name, cyc, BUSY, DONE,
                     cyc <= done_cyc, cyc == done_cyc);
         end
         if (!WR_ALLOW && exp_q.size() > 0) begin
            tests++;
            if (FD_WE_N !== 1'b1 || WRITEADDR !== exp_q[0].addr) begin
               fails++;
               $display("FAIL %s stall cyc=%0d we_n/addr got %b/%h required 1/%h", name, cyc,
                        FD_WE_N, WRITEADDR, exp_q[0].addr);
            end
         end
         check_write(name, cyc, nwr);
         @(posedge CLK);
      end
      START = 1'b0; WR_ALLOW = 1'b1;
      tests++;
      if (nwr != exp_writes || exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s write count got %0d required %0d (left %0d)", name, nwr, exp_writes, exp_q.size());
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0; START = 1'b0; WR_ALLOW = 1'b1;
      SPRITE_X = 8'h55; SPRITE_Y = 8'h66; SPRITE_ID = 4'h7;
      repeat (3) @(posedge CLK);
      #2;
      tests++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || FD_WE_N !== 1'b1 || ROM_ADDR !== 12'h0 || WRITEADDR !== 16'h0) begin
         fails++;
         $display("FAIL reset busy/done/we_n/rom/wa got %b/%b/%b/%h/%h required 0/0/1/000/0000",
                  BUSY, DONE, FD_WE_N, ROM_ADDR, WRITEADDR);
      end
      RESET_N = 1'b1;
      repeat (2) @(posedge CLK);
   endtask

   task automatic test_basic();    run_copy("basic", 10, 20, 3, 0, 0, 0, 256);  endtask
   task automatic test_clip();     run_copy("clip", 250, 248, 9, 0, 0, 0, 48); endtask
   task automatic test_stall();    run_copy("stall", 10, 20, 3, 0, 7, 0, 256); endtask
   task automatic test_start_ign(); run_copy("start_ign", 40, 60, 12, 0, 0, 1, 256); endtask

   task automatic test_transparency();
`ifdef SPRITE_TRANSPARENCY_EN
      run_copy("transp", 0, 0, 1, 1, 0, 0, 128);
`else
      run_copy("transp", 0, 0, 1, 1, 0, 0, 256);
`endif
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      int nwr = 0;
      build_exp(10, 20, 3, 0, 0);
      rom_mode = 0;
      @(posedge CLK); #1;
      SPRITE_X = 8'd10; SPRITE_Y = 8'd20; SPRITE_ID = 4'd3; START = 1'b1; WR_ALLOW = 1'b1;
      @(posedge CLK);
      repeat (99) begin
         #1; cyc++; START = 1'b0;
         @(negedge CLK);
         check_write("reset_mid", cyc, nwr);
         @(posedge CLK);
      end
      #1;
      RESET_N = 1'b0;
      #2;
      tests++;
      if (FD_WE_N !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || nwr != 49) begin
         fails++;
         $display("FAIL reset_mid we_n/busy/done/writes got %b/%b/%b/%0d required 1/0/0/49",
                  FD_WE_N, BUSY, DONE, nwr);
      end
      repeat (3) @(posedge CLK);
      #1 RESET_N = 1'b1;
      repeat (20) begin
         @(negedge CLK);
         tests++;
         if (FD_WE_N !== 1'b1 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid idle we_n/busy got %b/%b required 1/0", FD_WE_N, BUSY);
         end
      end
      run_copy("after_reset", 10, 20, 3, 0, 0, 0, 256);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clip();
      test_stall();
      test_start_ign();
      test_reset_mid();
      test_transparency();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
